// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// config register map, bus widths and the source priority ranking.
package intc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned VEC_W  = 16;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ISR     = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Lower rank = more urgent; the trap id (== nsrc) outranks every irq_in.
    function automatic logic [7:0] prio_rank(input logic [7:0] id, input logic [7:0] nsrc);
        return (id == nsrc) ? 8'd0 : 8'(id + 8'd1);
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-facing port of the interrupt controller: config register bus plus
// the req/ack/EOI handshake. The CPU is master, the controller is slave.
interface intr_ctrl_if;
    import intc_pkg::*;

    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] cfg_rdata;
    logic              cpu_irq;
    logic [VEC_W-1:0]  cpu_vec;
    logic              cpu_ack;
    logic              cpu_eoi;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cpu_ack, cpu_eoi,
        input  cfg_rdata, cpu_irq, cpu_vec
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cpu_ack, cpu_eoi,
        output cfg_rdata, cpu_irq, cpu_vec
    );

endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: bit N-1 (trap) wins, then bit 0, 1, ... N-2.
module intr_prio_enc #(
    parameter int unsigned N   = 5,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] id,
    output logic           valid
);

    always_comb begin
        id    = IDW'(0);
        valid = |req;
        // Descending scan so the lowest set irq index is the last to write.
        for (int i = int'(N) - 2; i >= 0; i--) begin
            if (req[i]) id = IDW'(i);
        end
        if (req[N-1]) id = IDW'(N - 1);
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, masking, fixed priority,
// req/ack/EOI handshake with per-source vectors. Nesting in INTC_NEST_EN.
module intr_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned NSRC       = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0008,
    parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            trap,
    intr_ctrl_if.slave      bus
);

    localparam int unsigned NS1 = NSRC + 1;
    localparam int unsigned IDW = $clog2(NS1);

    state_e           state, state_nxt;
    logic [NS1-1:0]   pend, pend_nxt;
    logic [NS1-1:0]   isr, isr_nxt;
    logic [NSRC-1:0]  enable;
    logic [NSRC-1:0]  irq_prev;
    logic             trap_prev;
    logic             gie;
    logic [IDW-1:0]   cur_id, cur_id_nxt;
    logic             cpu_irq_q, irq_nxt;
    logic [VEC_W-1:0] cpu_vec_q, vec_nxt;

    logic [NS1-1:0]   edges, elig, w1c, ack_clr, eoi_clr;
    logic [IDW-1:0]   elig_id, isr_hi_id;
    logic             elig_valid, isr_hi_valid;
    logic             wr_enable, wr_pending, wr_ctrl;
    logic             nest_ok;
    logic             unused_wdata;

    function automatic logic [VEC_W-1:0] vec_of(input logic [IDW-1:0] id);
        return VEC_W'(VEC_BASE + VEC_W'(id) * VEC_STRIDE);
    endfunction

    assign edges = {trap & ~trap_prev, irq_in & ~irq_prev};
    assign elig  = pend & {1'b1, enable & {NSRC{gie}}};

    assign wr_enable  = bus.cfg_we && (bus.cfg_addr == ADDR_ENABLE);
    assign wr_pending = bus.cfg_we && (bus.cfg_addr == ADDR_PENDING);
    assign wr_ctrl    = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
    assign w1c        = wr_pending ? bus.cfg_wdata[NS1-1:0] : '0;
    assign unused_wdata = ^bus.cfg_wdata[DATA_W-1:NS1];

    intr_prio_enc #(.N(NS1), .IDW(IDW)) u_enc_elig (
        .req   (elig),
        .id    (elig_id),
        .valid (elig_valid)
    );

    intr_prio_enc #(.N(NS1), .IDW(IDW)) u_enc_isr (
        .req   (isr),
        .id    (isr_hi_id),
        .valid (isr_hi_valid)
    );

`ifdef INTC_NEST_EN
    assign nest_ok = elig_valid &&
                     (prio_rank(8'(elig_id), 8'(NSRC)) < prio_rank(8'(isr_hi_id), 8'(NSRC)));
`else
    assign nest_ok = 1'b0;
`endif

    // Handshake FSM; a committed request holds id/vec until ack.
    always_comb begin
        state_nxt  = state;
        cur_id_nxt = cur_id;
        irq_nxt    = cpu_irq_q;
        vec_nxt    = cpu_vec_q;
        isr_nxt    = isr;
        ack_clr    = '0;
        eoi_clr    = '0;
        case (state)
            ST_IDLE: begin
                if (elig_valid) begin
                    state_nxt  = ST_REQ;
                    cur_id_nxt = elig_id;
                    irq_nxt    = 1'b1;
                    vec_nxt    = vec_of(elig_id);
                end
            end
            ST_REQ: begin
                if (bus.cpu_ack) begin
                    state_nxt = ST_SERVICE;
                    irq_nxt   = 1'b0;
                    ack_clr   = NS1'(1) << cur_id;
                    isr_nxt   = isr | ack_clr;
                end
            end
            ST_SERVICE: begin
                if (bus.cpu_eoi) begin
                    eoi_clr = isr_hi_valid ? (NS1'(1) << isr_hi_id) : '0;
                    isr_nxt = isr & ~eoi_clr;
                    if (isr_nxt == '0) state_nxt = ST_IDLE;
                end else if (nest_ok) begin
                    state_nxt  = ST_REQ;
                    cur_id_nxt = elig_id;
                    irq_nxt    = 1'b1;
                    vec_nxt    = vec_of(elig_id);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A fresh edge beats any clear of the same bit in this cycle.
        pend_nxt = (pend & ~(w1c | ack_clr)) | edges;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= '0;
            isr       <= '0;
            enable    <= '0;
            gie       <= 1'b0;
            irq_prev  <= '0;
            trap_prev <= 1'b0;
            cur_id    <= '0;
            cpu_irq_q <= 1'b0;
            cpu_vec_q <= '0;
        end else begin
            pend      <= pend_nxt;
            isr       <= isr_nxt;
            irq_prev  <= irq_in;
            trap_prev <= trap;
            cur_id    <= cur_id_nxt;
            cpu_irq_q <= irq_nxt;
            cpu_vec_q <= vec_nxt;
            if (wr_enable) enable <= bus.cfg_wdata[NSRC-1:0];
            if (wr_ctrl)   gie    <= bus.cfg_wdata[0];
        end
    end

    assign bus.cpu_irq = cpu_irq_q;
    assign bus.cpu_vec = cpu_vec_q;

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            ADDR_ENABLE:  bus.cfg_rdata = DATA_W'(enable);
            ADDR_PENDING: bus.cfg_rdata = DATA_W'(pend);
            ADDR_ISR:     bus.cfg_rdata = DATA_W'(isr);
            ADDR_CTRL:    bus.cfg_rdata = DATA_W'(gie);
            default:      bus.cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed handshake scenarios plus random traffic,
// every cycle compared against a set-based reference model.
module tb_intr_ctrl;

    localparam int unsigned NSRC    = 4;
    localparam int unsigned NS1     = NSRC + 1;
    localparam logic [15:0] VBASE   = 16'h0008;
    localparam logic [15:0] VSTRIDE = 16'h0002;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic [NSRC-1:0] irq_in = '0;
    logic            trap   = 1'b0;

    intr_ctrl_if bus ();

    intr_ctrl #(
        .NSRC       (NSRC),
        .VEC_BASE   (VBASE),
        .VEC_STRIDE (VSTRIDE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .trap   (trap),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Stimulus applied on the next step
    logic            s_rst, s_trap, s_we, s_ack, s_eoi;
    logic [NSRC-1:0] s_irq;
    logic [1:0]      s_addr;
    logic [15:0]     s_wdata;

    // Reference model state
    bit [NS1-1:0]  m_pend, m_isr;
    bit [NSRC-1:0] m_en, m_prev;
    bit            m_gie, m_prevt, m_req;
    int            m_id;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rank(input int id);
        return (id == int'(NSRC)) ? 0 : id + 1;
    endfunction

    function automatic logic [15:0] vec_of(input int id);
        return 16'(int'(VBASE) + id * int'(VSTRIDE));
    endfunction

    // Most urgent member of a set, -1 if empty
    function automatic int top_of(input bit [NS1-1:0] set);
        int best = -1;
        for (int i = 0; i < int'(NS1); i++)
            if (set[i] && (best < 0 || rank(i) < rank(best))) best = i;
        return best;
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return 16'(m_en);
            2'd1:    return 16'(m_pend);
            2'd2:    return 16'(m_isr);
            default: return 16'(m_gie);
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_isr = '0; m_en = '0; m_prev = '0;
        m_gie = 0; m_prevt = 0; m_req = 0; m_id = 0;
    endtask

    task automatic model_advance();
        bit [NS1-1:0] elig, nxt;
        int best, hi;
        for (int i = 0; i < int'(NS1); i++)
            elig[i] = m_pend[i] && (i == int'(NSRC) || (m_en[i] && m_gie));
        best = top_of(elig);
        hi   = top_of(m_isr);
        nxt  = m_pend;
        if (s_we && s_addr == 2'd1) nxt = nxt & ~s_wdata[NS1-1:0];
        if (m_req) begin
            if (s_ack) begin
                nxt[m_id] = 0; m_isr[m_id] = 1; m_req = 0;
            end
        end else if (hi >= 0) begin
            if (s_eoi) m_isr[hi] = 0;
`ifdef INTC_NEST_EN
            else if (best >= 0 && rank(best) < rank(hi)) begin
                m_req = 1; m_id = best;
            end
`endif
        end else if (best >= 0) begin
            m_req = 1; m_id = best;
        end
        for (int i = 0; i < int'(NSRC); i++)
            if (s_irq[i] && !m_prev[i]) nxt[i] = 1;
        if (s_trap && !m_prevt) nxt[NSRC] = 1;
        m_pend  = nxt;
        m_prev  = s_irq;
        m_prevt = s_trap;
        if (s_we && s_addr == 2'd0) m_en  = s_wdata[NSRC-1:0];
        if (s_we && s_addr == 2'd3) m_gie = s_wdata[0];
    endtask

    // One clock: drive, compare against the model, then advance the model
    task automatic step();
        @(negedge clk);
        reset         = s_rst;
        irq_in        = s_irq;
        trap          = s_trap;
        bus.cfg_we    = s_we;
        bus.cfg_addr  = s_addr;
        bus.cfg_wdata = s_wdata;
        bus.cpu_ack   = s_ack;
        bus.cpu_eoi   = s_eoi;
        #1;
        check_eq("cpu_irq", 16'(bus.cpu_irq), 16'(m_req));
        if (m_req) check_eq("cpu_vec", bus.cpu_vec, vec_of(m_id));
        check_eq("cfg_rdata", bus.cfg_rdata, model_read(s_addr));
        if (s_rst) model_reset();
        else       model_advance();
        s_we = 0; s_ack = 0; s_eoi = 0; s_rst = 0;
    endtask

    task automatic write(input logic [1:0] a, input logic [15:0] d);
        s_we = 1; s_addr = a; s_wdata = d;
        step();
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [15:0] exp);
        s_addr = a;
        step();
        check_eq(tag, bus.cfg_rdata, exp);
    endtask

    task automatic pulse(input logic [NSRC-1:0] mask);
        s_irq = mask; step();
        s_irq = '0;   step();
    endtask

    // Leaves the bench at a sample point where the request should be visible
    task automatic wait_irq();
        for (int n = 0; n < 12 && !m_req; n++) step();
        step();
    endtask

    task automatic ack();
        s_ack = 1; step();
    endtask

    task automatic eoi();
        s_eoi = 1; step();
    endtask

    task automatic expect_req(input string tag, input logic [15:0] v);
        check_eq({tag, "_irq"}, 16'(bus.cpu_irq), 16'h0001);
        check_eq({tag, "_vec"}, bus.cpu_vec, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        s_rst = 0; s_irq = '0; s_trap = 0; s_we = 0; s_addr = '0;
        s_wdata = '0; s_ack = 0; s_eoi = 0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.cpu_ack = 0; bus.cpu_eoi = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        model_reset();

        // Reset state
        peek("rst_enable", 2'd0, 16'h0000);
        check_eq("rst_irq", 16'(bus.cpu_irq), 16'h0000);
        check_eq("rst_vec", bus.cpu_vec, 16'h0000);
        peek("rst_pending", 2'd1, 16'h0000);
        peek("rst_isr", 2'd2, 16'h0000);
        peek("rst_ctrl", 2'd3, 16'h0000);

        // 1: basic request with exact latency
        write(2'd0, 16'h0001);
        write(2'd3, 16'h0001);
        s_irq = 4'b0001; step();
        s_irq = '0; s_addr = 2'd1; step();
        check_eq("t1_pend_n1", bus.cfg_rdata, 16'h0001);
        check_eq("t1_irq_n1", 16'(bus.cpu_irq), 16'h0000);
        step();
        expect_req("t1_n2", 16'h0008);
        ack();
        peek("t1_isr", 2'd2, 16'h0001);
        check_eq("t1_irq_acked", 16'(bus.cpu_irq), 16'h0000);
        eoi();
        peek("t1_isr_eoi", 2'd2, 16'h0000);

        // 2: two simultaneous sources, priority order
        write(2'd0, 16'h0006);
        pulse(4'b0110);
        wait_irq();
        expect_req("t2_first", 16'h000A);
        ack();
        eoi();
        wait_irq();
        expect_req("t2_second", 16'h000C);
        ack();
        eoi();
        step();

        // 3: trap ignores gie/ENABLE; masked source only pends
        write(2'd3, 16'h0000);
        write(2'd0, 16'h0000);
        s_trap = 1; step();
        s_trap = 0;
        wait_irq();
        expect_req("t3_trap", 16'h0010);
        pulse(4'b0001);
        expect_req("t3_hold", 16'h0010);
        peek("t3_pend", 2'd1, 16'h0011);
        ack();
        peek("t3_isr", 2'd2, 16'h0010);
        eoi();
        step(); step();
        check_eq("t3_masked_irq", 16'(bus.cpu_irq), 16'h0000);
        peek("t3_pend_masked", 2'd1, 16'h0001);
        write(2'd1, 16'h001F);
        peek("t3_pend_w1c", 2'd1, 16'h0000);

        // 4: edge beats W1C; committed request survives mask changes
        write(2'd3, 16'h0001);
        write(2'd0, 16'h0002);
        s_irq = 4'b0010; s_we = 1; s_addr = 2'd1; s_wdata = 16'h0002;
        step();
        s_irq = '0;
        peek("t4_setwin", 2'd1, 16'h0002);
        wait_irq();
        expect_req("t4_req", 16'h000A);
        write(2'd0, 16'h0000);
        expect_req("t4_en0", 16'h000A);
        write(2'd3, 16'h0000);
        expect_req("t4_gie0", 16'h000A);
        ack();
        eoi();
        step();
        check_eq("t4_idle_irq", 16'(bus.cpu_irq), 16'h0000);

        // 5: higher-priority source during service
        write(2'd3, 16'h0001);
        write(2'd0, 16'h0005);
        pulse(4'b0100);
        wait_irq();
        expect_req("t5_id2", 16'h000C);
        ack();
        step();
        pulse(4'b0001);
`ifdef INTC_NEST_EN
        wait_irq();
        expect_req("t5_nest", 16'h0008);
        ack();
        peek("t5_isr_both", 2'd2, 16'h0005);
        eoi();
        peek("t5_isr_eoi1", 2'd2, 16'h0004);
        eoi();
        peek("t5_isr_eoi2", 2'd2, 16'h0000);
`else
        repeat (3) step();
        check_eq("t5_no_nest", 16'(bus.cpu_irq), 16'h0000);
        peek("t5_isr", 2'd2, 16'h0004);
        eoi();
        wait_irq();
        expect_req("t5_after", 16'h0008);
        ack();
        eoi();
`endif
        step();

        // 6: reset in REQ and in SERVICE, stray ack/eoi afterwards
        pulse(4'b0001);
        wait_irq();
        expect_req("t6_req", 16'h0008);
        s_rst = 1; step();
        step();
        check_eq("t6_irq_rst", 16'(bus.cpu_irq), 16'h0000);
        peek("t6_en", 2'd0, 16'h0000);
        peek("t6_pend", 2'd1, 16'h0000);
        peek("t6_isr", 2'd2, 16'h0000);
        peek("t6_ctrl", 2'd3, 16'h0000);
        ack();
        eoi();
        check_eq("t6_stray", 16'(bus.cpu_irq), 16'h0000);
        write(2'd0, 16'h0001);
        write(2'd3, 16'h0001);
        pulse(4'b0001);
        wait_irq();
        ack();
        peek("t6_isr_svc", 2'd2, 16'h0001);
        s_rst = 1; step();
        step();
        check_eq("t6_irq_rst2", 16'(bus.cpu_irq), 16'h0000);
        peek("t6_isr2", 2'd2, 16'h0000);

        // Random traffic against the model
        s_irq = '0; s_trap = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < int'(NSRC); i++)
                if ($urandom_range(3) == 0) s_irq[i] = ~s_irq[i];
            if ($urandom_range(15) == 0) s_trap = ~s_trap;
            s_addr  = 2'($urandom_range(3));
            s_we    = ($urandom_range(5) == 0);
            s_wdata = 16'($urandom);
            if (s_we && s_addr == 2'd3 && $urandom_range(3) != 0) s_wdata[0] = 1'b1;
            s_ack = m_req ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            s_eoi = ($urandom_range(4) == 0);
            s_rst = ($urandom_range(299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
